// File: rtl/joystick_reader.sv
`default_nettype none
// joystick_reader: SPI mode-0 master polling a PmodJSTK once per poll period.
// Publishes raw X/Y, buttons and a 0..9 quantized X position.
module joystick_reader #(
    parameter int SCLK_HALF = 50,
    parameter int SS_WAIT   = 1500,
    parameter int GAP_WAIT  = 1000,
    parameter int POLL_WAIT = 100000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       miso_i,
    output logic       ss_n_o,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic [3:0] joystick_data_o,
    output logic [9:0] x_raw_o,
    output logic [9:0] y_raw_o,
    output logic [2:0] buttons_o,
    output logic       sample_valid_o
);

    localparam int MAX_A   = (SS_WAIT > GAP_WAIT) ? SS_WAIT : GAP_WAIT;
    localparam int MAX_B   = (POLL_WAIT > 2 * SCLK_HALF) ? POLL_WAIT : 2 * SCLK_HALF;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] SETUP_END = CW'(SS_WAIT);
    localparam logic [CW-1:0] HALF_END  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] BIT_END   = CW'(2 * SCLK_HALF - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP_WAIT - 1);
    localparam logic [CW-1:0] POLL_END  = CW'(POLL_WAIT - 1);

    typedef enum logic [2:0] {
        ST_SETUP = 3'd0,
        ST_SHIFT = 3'd1,
        ST_GAP   = 3'd2,
        ST_DONE  = 3'd3,
        ST_POLL  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [2:0]      byte_q, byte_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [9:0]      x_asm_q, x_asm_d;
    logic [9:0]      y_asm_q, y_asm_d;
    logic            ss_n_q, ss_n_d;
    logic            sclk_q, sclk_d;
    logic [3:0]      joy_q, joy_d;
    logic [9:0]      x_raw_q, x_raw_d;
    logic [9:0]      y_raw_q, y_raw_d;
    logic [2:0]      buttons_q, buttons_d;
    logic            valid_q, valid_d;
    logic [3:0]      quant;

    // X*5 in 13 bits, top four bits give the 0..9 position.
    assign quant = 4'((13'(x_asm_q) * 13'd5) >> 9);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_SETUP;
            cnt_q     <= '0;
            bit_q     <= 3'd7;
            byte_q    <= 3'd0;
            shreg_q   <= 8'd0;
            x_asm_q   <= 10'd0;
            y_asm_q   <= 10'd0;
            ss_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            joy_q     <= 4'd5;
            x_raw_q   <= 10'd512;
            y_raw_q   <= 10'd512;
            buttons_q <= 3'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shreg_q   <= shreg_d;
            x_asm_q   <= x_asm_d;
            y_asm_q   <= y_asm_d;
            ss_n_q    <= ss_n_d;
            sclk_q    <= sclk_d;
            joy_q     <= joy_d;
            x_raw_q   <= x_raw_d;
            y_raw_q   <= y_raw_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shreg_d   = shreg_q;
        x_asm_d   = x_asm_q;
        y_asm_d   = y_asm_q;
        sclk_d    = sclk_q;
        joy_d     = joy_q;
        x_raw_d   = x_raw_q;
        y_raw_d   = y_raw_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        unique case (state_q)
            ST_SETUP: begin
                if (cnt_q == SETUP_END) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    byte_d  = 3'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == HALF_END) begin
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[6:0], miso_i};
                    cnt_d   = cnt_q + CW'(1);
                end else if (cnt_q == BIT_END) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    if (bit_q == 3'd0) begin
                        state_d = ST_GAP;
                        case (byte_q)
                            3'd0:    x_asm_d[7:0] = shreg_q;
                            3'd1:    x_asm_d[9:8] = shreg_q[1:0];
                            3'd2:    y_asm_d[7:0] = shreg_q;
                            3'd3:    y_asm_d[9:8] = shreg_q[1:0];
                            default: begin
                                // Last byte: publish everything on this edge.
                                state_d   = ST_DONE;
                                x_raw_d   = x_asm_q;
                                y_raw_d   = y_asm_q;
                                buttons_d = shreg_q[2:0];
                                joy_d     = quant;
                                valid_d   = 1'b1;
                            end
                        endcase
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_END) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    byte_d  = byte_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_POLL;
                cnt_d   = '0;
            end
            ST_POLL: begin
                if (cnt_q == POLL_END) begin
                    state_d = ST_SETUP;
                    // SS_n falls on this edge, so it already counts as one setup cycle.
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_SETUP;
                cnt_d   = '0;
            end
        endcase
        ss_n_d = (state_d == ST_DONE) || (state_d == ST_POLL);
    end

    assign ss_n_o          = ss_n_q;
    assign sclk_o          = sclk_q;
    assign mosi_o          = 1'b0;
    assign joystick_data_o = joy_q;
    assign x_raw_o         = x_raw_q;
    assign y_raw_o         = y_raw_q;
    assign buttons_o       = buttons_q;
    assign sample_valid_o  = valid_q;

endmodule
`default_nettype wire

// File: doc/joystick_reader.md
# joystick_reader

SPI master that polls the PmodJSTK two-axis joystick and produces the quantized horizontal position consumed by the player movement logic. It also publishes raw axis values and button states. It runs continuously from reset, performing one 5-byte SPI transaction every poll period. Outputs update atomically at the end of each completed transaction.

## Interface
- SCLK_HALF, 50: Clk cycles per SCLK half-period (SCLK = Clk/(2·SCLK_HALF)); minimum 2
- SS_WAIT, 1500: Clk cycles from SS_n falling to start of first bit; minimum 1
- GAP_WAIT, 1000: idle Clk cycles between bytes, SCLK low; minimum 1
- POLL_WAIT, 100000: idle Clk cycles with SS_n high between transactions; minimum 1
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- MISO  in  1  serial data from joystick
- SS_n  out  1  slave select, active-low
- SCLK  out  1  SPI clock, mode 0 (idles low)
- MOSI  out  1  held 0 (LED command bytes not used)
- Joystick_data  out  4  quantized X position, 0..9, neutral 5
- X_raw  out  10  last X reading
- Y_raw  out  10  last Y reading
- Buttons  out  3  last button byte bits [2:0]
- Sample_valid  out  1  one-cycle pulse when outputs update

## Operation
- States: SETUP, SHIFT, GAP, DONE, POLL.
- Reset values: SS_n=1, SCLK=0, MOSI=0, Joystick_data=5, X_raw=512, Y_raw=512, Buttons=0, Sample_valid=0, state=SETUP, byte index 0.
- SETUP: SS_n=0. Count SS_WAIT cycles, then enter SHIFT at bit 7 of byte 0.
- SHIFT, per bit, MSB first:
  - SCLK low for SCLK_HALF cycles.
  - SCLK rises; MISO is sampled on the same Clk edge that drives SCLK high.
  - SCLK high for SCLK_HALF cycles.
  - SCLK falls.
- After the 8th falling edge, the byte is stored:
  - bytes 0–3 go to GAP;
  - byte 4 goes to DONE.
- GAP: SCLK=0, SS_n=0. Count GAP_WAIT cycles, advance the byte index, then enter SHIFT.
- Byte map:
  - X = {byte1[1:0], byte0}
  - Y = {byte3[1:0], byte2}
  - Buttons = byte4[2:0]
  - Unused high bits are ignored.
- DONE (one cycle):
  - SS_n=1.
  - X_raw, Y_raw, Buttons and Joystick_data all load on the same edge.
  - Sample_valid=1 for exactly this cycle.
  - Next state is POLL.
- POLL: SS_n=1. Count POLL_WAIT cycles, then enter SETUP.
- Quantization: product = X·5, 13 bits wide (max 5115, no overflow). Joystick_data = product[12:9].
  - X=0 → 0; X=512 → 5; X=1023 → 9.
  - Downstream thresholds: >6 moves right, <4 moves left, so 4..6 is the dead zone.
- Until the first transaction completes, outputs hold their reset values. The player therefore sees neutral.
- Reset asserted mid-transaction:
  - All outputs immediately return to reset values, with SS_n high and SCLK low.
  - Partially shifted bytes are discarded.

## Timing
- SS_n falls on the first rising Clk edge after Reset_n deasserts.
- First SCLK rise: SS_WAIT + SCLK_HALF cycles after SS_n falls.
- Transaction length from SS_n fall to the DONE edge: SS_WAIT + 80·SCLK_HALF + 4·GAP_WAIT cycles.
- SS_n stays high for 1 + POLL_WAIT cycles between transactions.
- Sample_valid to Joystick_data valid: 0 cycles, same edge.
- SCLK, SS_n and MOSI are registered outputs with no combinational path from MISO.

## Test plan
All scenarios use SCLK_HALF=2, SS_WAIT=4, GAP_WAIT=3, POLL_WAIT=10, with a mode-0 slave model that drives MISO on SCLK falling edges.

- Reset behaviour: hold Reset_n low for 5 cycles.
  - During reset: SS_n=1, SCLK=0, Joystick_data=5, X_raw=512, Sample_valid=0.
  - After release: SS_n falls on the first edge, and the first SCLK rise comes 6 cycles later.
- Neutral and extremes: slave returns X=512, then X=1023, then X=0.
  - Joystick_data is 5, then 9, then 0.
  - Each value updates on the Sample_valid pulse.
  - Each transaction is 4+160+12 = 176 cycles.
- Threshold points: X=700 → Joystick_data=6; X=820 → Joystick_data=8; X=300 → Joystick_data=2.
- Full field decode: slave bytes 0xFF,0x03,0x34,0x02,0x05.
  - X_raw=1023, Y_raw=564, Buttons=3'b101.
  - Sample_valid is high for exactly 1 cycle.
  - SS_n is high for 11 cycles before the next fall.
- Reset mid-transaction: assert Reset_n low during byte 2.
  - SS_n goes high and SCLK low immediately (asynchronously).
  - Outputs show reset values and there is no Sample_valid.
  - After release, a fresh 176-cycle transaction completes with correct data.
- Protocol check: over 3 transactions, verify:
  - MOSI is always 0;
  - exactly 40 SCLK rising edges per SS_n-low window;
  - the SCLK-low gap between bytes is at least 3 cycles.
